// File: rtl/sram_bank_arbiter_if.sv
// Requester and bank-side bus of the two-port SRAM bank arbiter.
// slave modport: arbiter side. master modport: requesters plus bank array.
interface sram_bank_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int BANKS = 4
);
  localparam int RW = $clog2(DEPTH);
  localparam int BW = $clog2(BANKS);
  localparam int GW = RW + BW;

  logic                   req0_valid;
  logic                   req0_ready;
  logic                   req0_we;
  logic [GW-1:0]          req0_addr;
  logic [WIDTH-1:0]       req0_wdata;
  logic                   rsp0_valid;
  logic [WIDTH-1:0]       rsp0_rdata;

  logic                   req1_valid;
  logic                   req1_ready;
  logic                   req1_we;
  logic [GW-1:0]          req1_addr;
  logic [WIDTH-1:0]       req1_wdata;
  logic                   rsp1_valid;
  logic [WIDTH-1:0]       rsp1_rdata;

  logic [BANKS-1:0]       bank_sel;
  logic [BANKS-1:0]       bank_wren;
  logic [BANKS-1:0]       bank_rden;
  logic [BANKS*RW-1:0]    bank_addr;
  logic [BANKS*WIDTH-1:0] bank_wr_data;
  logic [BANKS*WIDTH-1:0] bank_rd_data;
  logic [15:0]            conflict_cnt;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output bank_sel, bank_wren, bank_rden, bank_addr, bank_wr_data,
    input  bank_rd_data,
    output conflict_cnt
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  bank_sel, bank_wren, bank_rden, bank_addr, bank_wr_data,
    output bank_rd_data,
    input  conflict_cnt
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Two-requester arbiter in front of BANKS single-port SRAM banks.
// Low-order address interleave, per-bank round-robin on conflicts,
// fixed 1-cycle read response routed back to the issuing requester.
// Optional conflict statistics counter: define SRAM_ARB_STATS_EN.

// Per-bank grant and drive logic; one instance per bank.
module sram_bank_lane #(
  parameter int WIDTH = 16,
  parameter int RW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit0_i,
  input  logic             hit1_i,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic [RW-1:0]    row0_i,
  input  logic [RW-1:0]    row1_i,
  input  logic [WIDTH-1:0] wd0_i,
  input  logic [WIDTH-1:0] wd1_i,
  output logic             g0_o,
  output logic             g1_o,
  output logic             sel_o,
  output logic             wren_o,
  output logic             rden_o,
  output logic [RW-1:0]    addr_o,
  output logic [WIDTH-1:0] wdata_o
);
  logic contend;
  logic lastg_q, lastg_d;

  // lastg_q=1 means requester 1 won last, so requester 0 has priority next.
  assign contend = hit0_i & hit1_i;
  assign g0_o    = !rst & hit0_i & (!contend |  lastg_q);
  assign g1_o    = !rst & hit1_i & (!contend | !lastg_q);

  // Remember the winner of every handshake on this bank.
  always_comb begin
    lastg_d = lastg_q;
    if (g0_o)      lastg_d = 1'b0;
    else if (g1_o) lastg_d = 1'b1;
  end

  // Round-robin state register; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lastg_q <= 1'b1;
    else     lastg_q <= lastg_d;
  end

  // Drive the bank from the granted requester; wren/rden are exclusive by construction.
  always_comb begin
    sel_o   = 1'b0;
    wren_o  = 1'b0;
    rden_o  = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    if (g0_o) begin
      sel_o   = 1'b1;
      wren_o  = we0_i;
      rden_o  = !we0_i;
      addr_o  = row0_i;
      wdata_o = wd0_i;
    end else if (g1_o) begin
      sel_o   = 1'b1;
      wren_o  = we1_i;
      rden_o  = !we1_i;
      addr_o  = row1_i;
      wdata_o = wd1_i;
    end
  end
endmodule

module sram_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int BANKS = 4
) (
  input logic              clk,
  input logic              rst,
  sram_bank_arbiter_if.slave bus
);
  localparam int RW = $clog2(DEPTH);
  localparam int BW = $clog2(BANKS);
  localparam int GW = RW + BW;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [BW-1:0]    bank;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] wdata;
  } req_t;

  req_t [1:0]                   req;
  logic [1:0][BANKS-1:0]        hit;
  logic [1:0][BANKS-1:0]        gnt;
  logic [1:0]                   ready;
  logic [BANKS-1:0]             sel_w, wren_w, rden_w;
  logic [BANKS-1:0][RW-1:0]     addr_w;
  logic [BANKS-1:0][WIDTH-1:0]  wdat_w;
  logic [BANKS-1:0][WIDTH-1:0]  rd_w;
  logic [1:0]                   rsp_vld_q, rsp_vld_d;
  logic [1:0][BW-1:0]           rsp_bank_q, rsp_bank_d;
  logic [1:0][WIDTH-1:0]        rdata;

  // Decode global word address: low bits pick the bank, high bits the row.
  always_comb begin
    req[0].valid = bus.req0_valid;
    req[0].we    = bus.req0_we;
    req[0].bank  = bus.req0_addr[BW-1:0];
    req[0].row   = bus.req0_addr[GW-1:BW];
    req[0].wdata = bus.req0_wdata;
    req[1].valid = bus.req1_valid;
    req[1].we    = bus.req1_we;
    req[1].bank  = bus.req1_addr[BW-1:0];
    req[1].row   = bus.req1_addr[GW-1:BW];
    req[1].wdata = bus.req1_wdata;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign hit[0][b] = req[0].valid & (req[0].bank == BW'(b));
    assign hit[1][b] = req[1].valid & (req[1].bank == BW'(b));

    sram_bank_lane #(.WIDTH(WIDTH), .RW(RW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .hit0_i  (hit[0][b]),
      .hit1_i  (hit[1][b]),
      .we0_i   (req[0].we),
      .we1_i   (req[1].we),
      .row0_i  (req[0].row),
      .row1_i  (req[1].row),
      .wd0_i   (req[0].wdata),
      .wd1_i   (req[1].wdata),
      .g0_o    (gnt[0][b]),
      .g1_o    (gnt[1][b]),
      .sel_o   (sel_w[b]),
      .wren_o  (wren_w[b]),
      .rden_o  (rden_w[b]),
      .addr_o  (addr_w[b]),
      .wdata_o (wdat_w[b])
    );
  end

  // Each requester targets one bank, so ready is the OR of its grants.
  assign ready[0] = |gnt[0];
  assign ready[1] = |gnt[1];
  assign rd_w     = bus.bank_rd_data;

  // Read handshake launches a response next cycle; remember which bank answers.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rsp_vld_d[n]  = ready[n] & !req[n].we;
      rsp_bank_d[n] = ready[n] ? req[n].bank : rsp_bank_q[n];
    end
  end

  // Response tracking registers; reset drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q  <= '0;
      rsp_bank_q <= '0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_bank_q <= rsp_bank_d;
    end
  end

  // Route the registered bank output back; zero when no response is due.
  always_comb begin
    for (int n = 0; n < 2; n++)
      rdata[n] = rsp_vld_q[n] ? rd_w[rsp_bank_q[n]] : '0;
  end

  assign bus.req0_ready   = ready[0];
  assign bus.req1_ready   = ready[1];
  assign bus.rsp0_valid   = rsp_vld_q[0];
  assign bus.rsp1_valid   = rsp_vld_q[1];
  assign bus.rsp0_rdata   = rdata[0];
  assign bus.rsp1_rdata   = rdata[1];
  assign bus.bank_sel     = sel_w;
  assign bus.bank_wren    = wren_w;
  assign bus.bank_rden    = rden_w;
  assign bus.bank_addr    = addr_w;
  assign bus.bank_wr_data = wdat_w;

`ifdef SRAM_ARB_STATS_EN
  logic        any_contend;
  logic [15:0] cnt_q, cnt_d;

  // Only one bank can be contended at a time: both valid on the same bank.
  assign any_contend = req[0].valid & req[1].valid & (req[0].bank == req[1].bank);

  // Saturating count of contended cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (any_contend && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.conflict_cnt = cnt_q;
`else
  assign bus.conflict_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural bank array model.
module tb_sram_bank_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int BANKS = 4;
  localparam int RW    = 10;
`ifdef SRAM_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_bank_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS)) bus ();

  sram_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bank model: registered read, write on select+wren; preloaded pattern while rst.
  logic [WIDTH-1:0]            mem [BANKS][DEPTH];
  logic [BANKS-1:0][WIDTH-1:0] rdq;
  assign bus.bank_rd_data = rdq;

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++) begin
        rdq[b] <= '0;
        for (int r = 0; r < DEPTH; r++) mem[b][r] <= 16'hC000 | 16'(b << 10) | 16'(r);
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (bus.bank_sel[b] && bus.bank_wren[b])
          mem[b][bus.bank_addr[b*RW +: RW]] <= bus.bank_wr_data[b*WIDTH +: WIDTH];
        if (bus.bank_sel[b] && bus.bank_rden[b])
          rdq[b] <= mem[b][bus.bank_addr[b*RW +: RW]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  task automatic rd0(input int a);
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 12'(a);
  endtask

  task automatic wr0(input int a, input logic [15:0] d);
    bus.req0_valid = 1; bus.req0_we = 1; bus.req0_addr = 12'(a); bus.req0_wdata = d;
  endtask

  task automatic rd1(input int a);
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 12'(a);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    tick(); tick();
    // Reset: a held request must not be granted or reach a bank.
    rd0(5); #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_sel", bus.bank_sel, 0);
    chk("rst_rsp0", bus.rsp0_valid, 0);
    chk("rst_cnt", bus.conflict_cnt, 0);
    idle(); rst = 0;

    // T1: write A5A5 to addr 5 (bank1 row1), then read it back.
    tick(); wr0(5, 16'hA5A5); #1;
    chk("t1_ready0", bus.req0_ready, 1);
    chk("t1_sel", bus.bank_sel, 4'b0010);
    chk("t1_wren", bus.bank_wren, 4'b0010);
    chk("t1_rden", bus.bank_rden, 4'b0000);
    chk("t1_row", bus.bank_addr[1*RW +: RW], 1);
    chk("t1_wdata", bus.bank_wr_data[1*WIDTH +: WIDTH], 16'hA5A5);
    tick(); rd0(5); #1;
    chk("t1_rd_ready", bus.req0_ready, 1);
    chk("t1_rd_rden", bus.bank_rden, 4'b0010);
    tick(); idle(); #1;
    chk("t1_rsp_vld", bus.rsp0_valid, 1);
    chk("t1_rsp_data", bus.rsp0_rdata, 16'hA5A5);
    chk("t1_rsp1_idle", bus.rsp1_valid, 0);
    tick();
    chk("t1_rsp_drop", bus.rsp0_valid, 0);
    chk("t1_rsp_zero", bus.rsp0_rdata, 0);

    // T2: parallel reads of different banks.
    rd0(0); rd1(1); #1;
    chk("t2_ready0", bus.req0_ready, 1);
    chk("t2_ready1", bus.req1_ready, 1);
    chk("t2_sel", bus.bank_sel, 4'b0011);
    tick(); idle(); #1;
    chk("t2_rsp0_vld", bus.rsp0_valid, 1);
    chk("t2_rsp1_vld", bus.rsp1_valid, 1);
    chk("t2_rsp0_data", bus.rsp0_rdata, 16'hC000);
    chk("t2_rsp1_data", bus.rsp1_rdata, 16'hC400);
    chk("t2_cnt", bus.conflict_cnt, 0);

    // T3: both hold reads to addr 8 (bank0 row2) from a fresh reset for 4 cycles.
    do_reset();
    rd0(8); rd1(8);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_ready0", bus.req0_ready, (k % 2 == 0));
      chk("t3_ready1", bus.req1_ready, (k % 2 == 1));
      chk("t3_row", bus.bank_addr[0 +: RW], 2);
      if (k > 0) begin
        chk("t3_rsp0_vld", bus.rsp0_valid, ((k - 1) % 2 == 0));
        chk("t3_rsp1_vld", bus.rsp1_valid, ((k - 1) % 2 == 1));
      end
      tick();
    end
    idle(); #1;
    chk("t3_last_rsp1", bus.rsp1_valid, 1);
    chk("t3_last_data", bus.rsp1_rdata, 16'hC002);
    chk("t3_last_rsp0", bus.rsp0_valid, 0);
    chk("t3_cnt", bus.conflict_cnt, STATS ? 4 : 0);

    // T4: write and read of addr 12 in the same cycle; writer wins.
    wr0(12, 16'h1234); rd1(12); #1;
    chk("t4_ready0", bus.req0_ready, 1);
    chk("t4_ready1", bus.req1_ready, 0);
    chk("t4_wren", bus.bank_wren, 4'b0001);
    chk("t4_excl_a", bus.bank_wren & bus.bank_rden, 0);
    tick(); bus.req0_valid = 0; #1;
    chk("t4_ready1_b", bus.req1_ready, 1);
    chk("t4_rden", bus.bank_rden, 4'b0001);
    chk("t4_excl_b", bus.bank_wren & bus.bank_rden, 0);
    tick(); idle(); #1;
    chk("t4_rsp1_vld", bus.rsp1_valid, 1);
    chk("t4_rsp1_data", bus.rsp1_rdata, 16'h1234);
    chk("t4_cnt", bus.conflict_cnt, STATS ? 5 : 0);

    // T5: move bank2 priority to req1, launch a read, reset before its response.
    rd0(2); rd1(6); #1;
    chk("t5_pre_ready0", bus.req0_ready, 1);
    chk("t5_pre_ready1", bus.req1_ready, 0);
    tick(); idle(); rd0(5); #1;
    chk("t5_rd_ready", bus.req0_ready, 1);
    tick(); rst = 1; #1;
    chk("t5_rst_rsp", bus.rsp0_valid, 0);
    chk("t5_rst_rdata", bus.rsp0_rdata, 0);
    chk("t5_rst_ready", bus.req0_ready, 0);
    chk("t5_rst_sel", bus.bank_sel, 0);
    tick(); rst = 0; idle(); #1;
    chk("t5_post_rsp", bus.rsp0_valid, 0);
    chk("t5_post_cnt", bus.conflict_cnt, 0);
    rd0(2); rd1(6); #1;
    chk("t5_lastg_r0", bus.req0_ready, 1);
    chk("t5_lastg_r1", bus.req1_ready, 0);
    tick(); idle();

`ifdef SRAM_ARB_STATS_EN
    // T6: saturate the conflict counter.
    rd0(8); rd1(8);
    repeat (70000) @(posedge clk);
    #1;
    chk("t6_sat", bus.conflict_cnt, 16'hFFFF);
    tick(); tick();
    chk("t6_nowrap", bus.conflict_cnt, 16'hFFFF);
    idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
